// File: rtl/ad9226_pkg.sv
// Shared constants and FSM encoding for the ADC packet path (AD9226 sampling
// into UDP frames sent through the W5500).
package ad9226_pkg;
    localparam int ADC_BITS        = 12;
    localparam int SAMPLES         = 4;
    localparam int WORD_W          = ADC_BITS * SAMPLES;
    localparam int LENGTH_UDP      = 245;
    localparam int BYTES_PER_WORD  = WORD_W / 8;
    localparam int BYTES_PER_FRAME = LENGTH_UDP * BYTES_PER_WORD;
    localparam int WORD_CNT_W      = 9;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        SHIFT,
        SEND,
        ACK
    } state_t;
endpackage

// File: rtl/word_byte_serializer.sv
// Splits one packed FIFO word into bytes, MSB first, under valid/ready;
// done pulses in the cycle the last byte is accepted.
module word_byte_serializer
    import ad9226_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              ready,
    output logic [7:0]        byte_out,
    output logic              valid,
    output logic              first_byte,
    output logic              last_byte,
    output logic              done
);
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [2:0]        idx_q, idx_d;
    logic              valid_q, valid_d;

    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        done    = 1'b0;
        if (load) begin
            shreg_d = word;
            idx_d   = 3'd0;
            valid_d = 1'b1;
        end else if (valid_q && ready) begin
            // Shifting left keeps the current byte at the top of the register.
            shreg_d = {shreg_q[WORD_W-9:0], 8'h00};
            if (idx_q == 3'(BYTES_PER_WORD - 1)) begin
                idx_d   = 3'd0;
                valid_d = 1'b0;
                done    = 1'b1;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign byte_out   = shreg_q[WORD_W-1 -: 8];
    assign valid      = valid_q;
    assign first_byte = (idx_q == 3'd0);
    assign last_byte  = (idx_q == 3'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/udp_frame_reader.sv
// Drains one UDP frame of packed ADC words from the FIFO, streams it bytewise
// to the W5500 TX writer, requests SEND and acknowledges the packer.
module udp_frame_reader
    import ad9226_pkg::*;
(
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              signal_to_wiznet5500,
    output logic              signal_from_wiznet5500,
    input  logic              fifo_empty,
    output logic              fifo_read_enable,
    input  logic [WORD_W-1:0] fifo_data,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_first,
    output logic              tx_last,
    output logic              send_request,
    input  logic              send_done,
    output logic              busy,
    output logic              overrun_err
);
    state_t                state_q, state_d;
    logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic                  sent_q, sent_d;
    logic                  overrun_q, overrun_d;

    logic       ser_load, ser_valid, ser_first, ser_last, ser_done;
    logic [7:0] ser_byte;

    word_byte_serializer u_ser (
        .clk        (sys_clk),
        .rst_n      (reset_n),
        .load       (ser_load),
        .word       (fifo_data),
        .ready      (tx_ready),
        .byte_out   (ser_byte),
        .valid      (ser_valid),
        .first_byte (ser_first),
        .last_byte  (ser_last),
        .done       (ser_done)
    );

    always_comb begin
        state_d                = state_q;
        word_cnt_d             = word_cnt_q;
        sent_d                 = sent_q;
        overrun_d              = overrun_q | (signal_to_wiznet5500 && state_q != IDLE);
        fifo_read_enable       = 1'b0;
        ser_load               = 1'b0;
        send_request           = 1'b0;
        signal_from_wiznet5500 = 1'b0;
        case (state_q)
            IDLE: begin
                if (signal_to_wiznet5500) begin
                    state_d    = FETCH;
                    word_cnt_d = '0;
                end
            end
            FETCH: begin
                if (!fifo_empty) begin
                    fifo_read_enable = 1'b1;
                    state_d          = LATCH;
                end
            end
            LATCH: begin
                ser_load   = 1'b1;
                word_cnt_d = word_cnt_q + 9'd1;
                state_d    = SHIFT;
            end
            SHIFT: begin
                if (ser_done)
                    state_d = (word_cnt_q == 9'(LENGTH_UDP)) ? SEND : FETCH;
            end
            SEND: begin
                // First cycle issues the request; send_done counts only afterwards.
                if (!sent_q) begin
                    send_request = 1'b1;
                    sent_d       = 1'b1;
                end else if (send_done) begin
                    sent_d  = 1'b0;
                    state_d = ACK;
                end
            end
            ACK: begin
                signal_from_wiznet5500 = 1'b1;
                state_d                = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            sent_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            sent_q     <= sent_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tx_valid    = ser_valid;
    assign tx_byte     = ser_valid ? ser_byte : 8'h00;
    assign tx_first    = ser_valid && ser_first && (word_cnt_q == 9'd1);
    assign tx_last     = ser_valid && ser_last && (word_cnt_q == 9'(LENGTH_UDP));
    assign busy        = (state_q != IDLE);
    assign overrun_err = overrun_q;
endmodule

// File: tb/tb_udp_frame_reader.sv
// Self-checking bench for udp_frame_reader: a behavioural FIFO with 1-cycle
// read latency feeds table-driven frame scenarios plus a mid-frame reset.
`timescale 1ns/1ps
module tb_udp_frame_reader;
    import ad9226_pkg::*;

    localparam int NW     = LENGTH_UDP;
    localparam int NB     = BYTES_PER_FRAME;
    localparam int BUDGET = 20000;

    logic              sys_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              signal_to = 1'b0;
    logic              signal_from;
    logic              fifo_empty;
    logic              fifo_read_enable;
    logic [WORD_W-1:0] fifo_data;
    logic [7:0]        tx_byte;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic              tx_first;
    logic              tx_last;
    logic              send_request;
    logic              send_done = 1'b0;
    logic              busy;
    logic              overrun_err;
    logic              starve = 1'b0;

    logic [WORD_W-1:0] mem [0:NW-1];
    int                rd_ptr = 0;
    int                errors = 0;
    int                checks = 0;

    typedef struct {
        int pat;
        bit bp;
        int starve_word;
        int ovr_at;
        int sd_delay;
        bit sd_early;
        bit stray;
        bit exp_ovr;
    } vec_t;

    udp_frame_reader dut (
        .sys_clk                (sys_clk),
        .reset_n                (reset_n),
        .signal_to_wiznet5500   (signal_to),
        .signal_from_wiznet5500 (signal_from),
        .fifo_empty             (fifo_empty),
        .fifo_read_enable       (fifo_read_enable),
        .fifo_data              (fifo_data),
        .tx_byte                (tx_byte),
        .tx_valid               (tx_valid),
        .tx_ready               (tx_ready),
        .tx_first               (tx_first),
        .tx_last                (tx_last),
        .send_request           (send_request),
        .send_done              (send_done),
        .busy                   (busy),
        .overrun_err            (overrun_err)
    );

    always #5 sys_clk = ~sys_clk;

    assign fifo_empty = starve || (rd_ptr >= NW);

    always @(posedge sys_clk) begin
        if (!reset_n) begin
            rd_ptr <= 0;
        end else if (fifo_read_enable && !fifo_empty) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Pattern 0 replicates the word index into every byte; pattern 1 gives
    // each byte of a word a distinct value so byte order is observable.
    function automatic logic [7:0] exp_byte(input int pat, input int k, input int j);
        logic [31:0] t;
        t = (pat == 0) ? 32'(k) : 32'(k * 7 + j * 41 + 3);
        return t[7:0];
    endfunction

    task automatic fill(input int pat);
        for (int k = 0; k < NW; k++)
            for (int j = 0; j < BYTES_PER_WORD; j++)
                mem[k][WORD_W-1-8*j -: 8] = exp_byte(pat, k, j);
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {tx_byte, tx_valid, tx_first, tx_last, fifo_read_enable,
                     send_request, signal_from, busy, overrun_err}, 0);
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        reset_n   = 1'b0;
        signal_to = 1'b0;
        send_done = 1'b0;
        tx_ready  = 1'b0;
        starve    = 1'b0;
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;
    endtask

    task automatic run_frame(input int id, input vec_t v, input int abort_at);
        int         byte_cnt, reads, rd_viol, order_err, stab_err, sreq, acks;
        int         cyc, sreq_cyc, sd_cyc, ack_cyc, starve_cnt, k, j;
        bit         early_next, ovr_done, prev_stall, done;
        logic [7:0] pb;
        logic       pf, pl;
        byte_cnt = 0; reads = 0; rd_viol = 0; order_err = 0; stab_err = 0;
        sreq = 0; acks = 0; sreq_cyc = -1; sd_cyc = -1; ack_cyc = -1;
        starve_cnt = 0; early_next = 0; ovr_done = 0; prev_stall = 0; done = 0;
        pb = 8'h00; pf = 1'b0; pl = 1'b0;
        fill(v.pat);

        if (v.stray) begin
            @(negedge sys_clk);
            send_done = 1'b1;
            @(negedge sys_clk);
            send_done = 1'b0;
            #1;
            check($sformatf("v%0d stray_done_busy", id), busy, 0);
            check($sformatf("v%0d stray_done_ack", id), signal_from, 0);
        end

        for (cyc = 0; cyc < BUDGET && !done; cyc++) begin
            @(negedge sys_clk);
            signal_to = (cyc == 0);
            if (v.ovr_at >= 0 && !ovr_done && byte_cnt >= v.ovr_at) begin
                signal_to = 1'b1;
                ovr_done  = 1'b1;
            end
            tx_ready  = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            send_done = early_next;
            if (sreq_cyc >= 0 && cyc == sreq_cyc + v.sd_delay) begin
                send_done = 1'b1;
                sd_cyc    = cyc;
            end
            early_next = 0;
            if (v.starve_word >= 0 && rd_ptr == v.starve_word && starve_cnt < 20) begin
                starve = 1'b1;
                starve_cnt++;
            end else begin
                starve = 1'b0;
            end
            #1;
            if (fifo_read_enable) begin
                reads++;
                if (fifo_empty) rd_viol++;
            end
            if (prev_stall && !(tx_valid && tx_byte == pb && tx_first == pf && tx_last == pl))
                stab_err++;
            prev_stall = tx_valid && !tx_ready;
            pb = tx_byte; pf = tx_first; pl = tx_last;
            if (tx_valid && tx_ready) begin
                k = byte_cnt / BYTES_PER_WORD;
                j = byte_cnt % BYTES_PER_WORD;
                if (byte_cnt >= NB || tx_byte != exp_byte(v.pat, k, j) ||
                    tx_first != (byte_cnt == 0) || tx_last != (byte_cnt == NB - 1))
                    order_err++;
                byte_cnt++;
                if (byte_cnt == NB && v.sd_early) early_next = 1;
                if (abort_at >= 0 && byte_cnt == abort_at) done = 1;
            end
            if (send_request) begin
                sreq++;
                if (sreq_cyc < 0) sreq_cyc = cyc;
            end
            if (signal_from) begin
                acks++;
                ack_cyc = cyc;
                done    = 1;
            end
        end

        check($sformatf("v%0d finished_in_budget", id), done, 1);
        check($sformatf("v%0d order_errors", id), order_err, 0);
        check($sformatf("v%0d read_while_empty", id), rd_viol, 0);
        if (abort_at >= 0) begin
            check($sformatf("v%0d bytes_before_abort", id), byte_cnt, abort_at);
            return;
        end
        check($sformatf("v%0d bytes", id), byte_cnt, NB);
        check($sformatf("v%0d reads", id), reads, NW);
        check($sformatf("v%0d stability_errors", id), stab_err, 0);
        check($sformatf("v%0d send_request_cycles", id), sreq, 1);
        check($sformatf("v%0d ack_pulses", id), acks, 1);
        check($sformatf("v%0d ack_after_send_done", id), ack_cyc - sd_cyc, 1);

        @(negedge sys_clk);
        signal_to = 1'b0;
        send_done = 1'b0;
        tx_ready  = 1'b0;
        starve    = 1'b0;
        #1;
        check($sformatf("v%0d idle_after_ack", id), {busy, signal_from, tx_valid}, 0);
        check($sformatf("v%0d overrun_err", id), overrun_err, v.exp_ovr);
    endtask

    initial begin
        vec_t vecs [6];
        vecs[0] = '{pat:0, bp:0, starve_word:-1,  ovr_at:-1,  sd_delay:3,    sd_early:0, stray:0, exp_ovr:0};
        vecs[1] = '{pat:1, bp:0, starve_word:-1,  ovr_at:-1,  sd_delay:1,    sd_early:0, stray:0, exp_ovr:0};
        vecs[2] = '{pat:1, bp:1, starve_word:-1,  ovr_at:-1,  sd_delay:2,    sd_early:0, stray:0, exp_ovr:0};
        vecs[3] = '{pat:1, bp:0, starve_word:100, ovr_at:-1,  sd_delay:4,    sd_early:0, stray:0, exp_ovr:0};
        vecs[4] = '{pat:0, bp:0, starve_word:-1,  ovr_at:300, sd_delay:2,    sd_early:0, stray:0, exp_ovr:1};
        vecs[5] = '{pat:1, bp:0, starve_word:-1,  ovr_at:-1,  sd_delay:1000, sd_early:1, stray:1, exp_ovr:0};

        repeat (2) @(negedge sys_clk);
        #1;
        check_all_zero("reset_state");

        for (int i = 0; i < 6; i++) begin
            apply_reset();
            run_frame(i, vecs[i], -1);
        end

        // Mid-frame reset: outputs must drop without waiting for a clock edge.
        apply_reset();
        run_frame(6, vecs[1], 700);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        repeat (2) @(negedge sys_clk);
        signal_to = 1'b0;
        reset_n   = 1'b1;
        run_frame(7, vecs[2], -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
